// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - address and data width helpers derived from framebuffer geometry
package calc_pkg;

  function automatic int num_column_address_bits(input int pixel_width);
    return (pixel_width > 1) ? $clog2(pixel_width) : 1;
  endfunction

  function automatic int num_row_address_bits(input int pixel_height);
    return (pixel_height > 1) ? $clog2(pixel_height) : 1;
  endfunction

  function automatic int num_pixelcolorselect_bits(input int bytes_per_pixel);
    return (bytes_per_pixel > 1) ? $clog2(bytes_per_pixel) : 1;
  endfunction

  // The RAM is written one byte of one pixel at a time.
  function automatic int num_data_a_bits();
    return 8;
  endfunction

endpackage : calc_pkg

// File: rtl/control_sched_pkg.sv
// rtl/control_sched_pkg.sv - shared types for the fill-command scheduler
package control_sched_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLIP     = 3'd1,
    RUN      = 3'd2,
    ACK      = 3'd3,
    COMPLETE = 3'd4
  } sched_state_t;

  typedef enum logic {
    CMD_FILL_AREA   = 1'b0,
    CMD_CLEAR_FRAME = 1'b1
  } cmd_kind_t;

endpackage : control_sched_pkg

// File: rtl/params.sv
// rtl/params.sv - default framebuffer geometry shared by the display blocks
package params;

  localparam int BYTES_PER_PIXEL = 2;
  localparam int PIXEL_WIDTH     = 12;
  localparam int PIXEL_HEIGHT    = 6;

endpackage : params

// File: rtl/control_subcmd_clip.sv
// rtl/control_subcmd_clip.sv - combinational rectangle clip against the frame
//
// Ports:
//   x1, y1             top-left corner of the requested rectangle
//   width, height      requested size, one bit wider than the address
//   empty              rectangle lies outside the frame or has zero size
//   clip_width/height  clipped size truncated to address width (full span
//                      wraps to the cast the fill engine expects)
module control_subcmd_clip
  import control_sched_pkg::*;
#(
  parameter int PIXEL_WIDTH  = params::PIXEL_WIDTH,
  parameter int PIXEL_HEIGHT = params::PIXEL_HEIGHT,
  localparam int CB = calc_pkg::num_column_address_bits(PIXEL_WIDTH),
  localparam int RB = calc_pkg::num_row_address_bits(PIXEL_HEIGHT)
) (
  input  logic [CB-1:0] x1,
  input  logic [RB-1:0] y1,
  input  logic [CB:0]   width,
  input  logic [RB:0]   height,
  output logic          empty,
  output logic [CB-1:0] clip_width,
  output logic [RB-1:0] clip_height
);

  localparam logic [CB:0] FULL_WIDTH  = (CB+1)'(PIXEL_WIDTH);
  localparam logic [RB:0] FULL_HEIGHT = (RB+1)'(PIXEL_HEIGHT);

  logic [CB:0] x1_ext;
  logic [RB:0] y1_ext;
  logic [CB:0] room_x;
  logic [RB:0] room_y;

  assign x1_ext = {1'b0, x1};
  assign y1_ext = {1'b0, y1};

  // Room to the frame edge; only meaningful when the corner is inside.
  assign room_x = FULL_WIDTH - x1_ext;
  assign room_y = FULL_HEIGHT - y1_ext;

  assign empty = (x1_ext >= FULL_WIDTH) || (y1_ext >= FULL_HEIGHT) ||
                 (width == '0) || (height == '0);

  // Compare at full width, then keep the low address bits of the minimum.
  assign clip_width  = (width <= room_x)  ? width[CB-1:0]  : room_x[CB-1:0];
  assign clip_height = (height <= room_y) ? height[RB-1:0] : room_y[RB-1:0];

endmodule : control_subcmd_clip

// File: rtl/control_subcmd_scheduler.sv
// rtl/control_subcmd_scheduler.sv - fill-command sequencer and framebuffer write-port arbiter
//
// Ports:
//   clk, reset                clock and asynchronous active-low reset
//   cmd_*                     command handshake in, one-cycle done/error out
//   fill_enable/ack/done      fill engine handshake
//   fill_x1..fill_color       clipped rectangle, registered in CLIP
//   fill_row..fill_we         engine RAM write request
//   px_req/px_gnt, px_*       direct single-pixel writer
//   ram_*                     framebuffer RAM write port
module control_subcmd_scheduler
  import control_sched_pkg::*;
#(
  parameter int BYTES_PER_PIXEL = params::BYTES_PER_PIXEL,
  parameter int PIXEL_WIDTH     = params::PIXEL_WIDTH,
  parameter int PIXEL_HEIGHT    = params::PIXEL_HEIGHT,
  parameter int WATCHDOG_CYCLES = PIXEL_WIDTH*PIXEL_HEIGHT*BYTES_PER_PIXEL+16,
  localparam int CB  = calc_pkg::num_column_address_bits(PIXEL_WIDTH),
  localparam int RB  = calc_pkg::num_row_address_bits(PIXEL_HEIGHT),
  localparam int PB  = calc_pkg::num_pixelcolorselect_bits(BYTES_PER_PIXEL),
  localparam int DB  = calc_pkg::num_data_a_bits(),
  localparam int COL = BYTES_PER_PIXEL*8
) (
  input  logic           clk,
  input  logic           reset,
  // command side
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_kind,
  input  logic [CB-1:0]  cmd_x1,
  input  logic [RB-1:0]  cmd_y1,
  input  logic [CB:0]    cmd_width,
  input  logic [RB:0]    cmd_height,
  input  logic [COL-1:0] cmd_color,
  output logic           cmd_done,
  output logic           cmd_error,
  // fill engine side
  output logic           fill_enable,
  output logic           fill_ack,
  input  logic           fill_done,
  output logic [CB-1:0]  fill_x1,
  output logic [RB-1:0]  fill_y1,
  output logic [CB-1:0]  fill_width,
  output logic [RB-1:0]  fill_height,
  output logic [COL-1:0] fill_color,
  input  logic [RB-1:0]  fill_row,
  input  logic [CB-1:0]  fill_column,
  input  logic [PB-1:0]  fill_pixel,
  input  logic [DB-1:0]  fill_data,
  input  logic           fill_we,
  // pixel writer side
  input  logic           px_req,
  output logic           px_gnt,
  input  logic [RB-1:0]  px_row,
  input  logic [CB-1:0]  px_column,
  input  logic [PB-1:0]  px_pixel,
  input  logic [DB-1:0]  px_data,
  // RAM side
  output logic [RB-1:0]  ram_row,
  output logic [CB-1:0]  ram_column,
  output logic [PB-1:0]  ram_pixel,
  output logic [DB-1:0]  ram_data,
  output logic           ram_write_enable
);

  localparam int WDW = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
  localparam logic [WDW-1:0] WD_LAST     = WDW'(WATCHDOG_CYCLES - 1);
  localparam logic [CB:0]    FULL_WIDTH  = (CB+1)'(PIXEL_WIDTH);
  localparam logic [RB:0]    FULL_HEIGHT = (RB+1)'(PIXEL_HEIGHT);

  sched_state_t   state;
  sched_state_t   state_next;
  logic           in_idle;
  logic           cmd_fire;
  logic           last_was_cmd;

  logic [CB-1:0]  req_x1;
  logic [RB-1:0]  req_y1;
  logic [CB:0]    req_width;
  logic [RB:0]    req_height;
  logic [COL-1:0] req_color;

  logic           clip_empty;
  logic [CB-1:0]  clip_width;
  logic [RB-1:0]  clip_height;

  logic [WDW-1:0] wd_count;
  logic           wd_expire;
  logic           error_q;

  assign in_idle = (state == IDLE);

  // Round-robin between command and pixel writer; gated by reset so that
  // nothing is accepted or granted while reset is held.
  assign cmd_ready = in_idle && reset && !(px_req && last_was_cmd);
  assign px_gnt    = in_idle && reset && px_req && !(cmd_valid && !last_was_cmd);
  assign cmd_fire  = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_was_cmd <= 1'b0;
    end else if (cmd_fire) begin
      last_was_cmd <= 1'b1;
    end else if (px_gnt) begin
      last_was_cmd <= 1'b0;
    end
  end

  // Capture the request; a clear substitutes the whole frame in black.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_x1     <= '0;
      req_y1     <= '0;
      req_width  <= '0;
      req_height <= '0;
      req_color  <= '0;
    end else if (cmd_fire) begin
      if (cmd_kind_t'(cmd_kind) == CMD_CLEAR_FRAME) begin
        req_x1     <= '0;
        req_y1     <= '0;
        req_width  <= FULL_WIDTH;
        req_height <= FULL_HEIGHT;
        req_color  <= '0;
      end else begin
        req_x1     <= cmd_x1;
        req_y1     <= cmd_y1;
        req_width  <= cmd_width;
        req_height <= cmd_height;
        req_color  <= cmd_color;
      end
    end
  end

  control_subcmd_clip #(
    .PIXEL_WIDTH  (PIXEL_WIDTH),
    .PIXEL_HEIGHT (PIXEL_HEIGHT)
  ) u_clip (
    .x1          (req_x1),
    .y1          (req_y1),
    .width       (req_width),
    .height      (req_height),
    .empty       (clip_empty),
    .clip_width  (clip_width),
    .clip_height (clip_height)
  );

  // Engine parameters are loaded once in CLIP and stay put for the fill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_x1     <= '0;
      fill_y1     <= '0;
      fill_width  <= '0;
      fill_height <= '0;
      fill_color  <= '0;
    end else if (state == CLIP) begin
      fill_x1     <= req_x1;
      fill_y1     <= req_y1;
      fill_width  <= clip_width;
      fill_height <= clip_height;
      fill_color  <= req_color;
    end
  end

  // Counts RUN cycles; restarted in CLIP so every fill gets a full budget.
  assign wd_expire = (wd_count == WD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_count <= '0;
    end else if (state == CLIP) begin
      wd_count <= '0;
    end else if ((state == RUN) && !wd_expire) begin
      wd_count <= wd_count + WDW'(1);
    end
  end

  // High exactly during the COMPLETE cycle that follows a watchdog abort;
  // a simultaneous fill_done takes the normal ACK path instead.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error_q <= 1'b0;
    end else begin
      error_q <= (state == RUN) && !fill_done && wd_expire;
    end
  end

  assign cmd_error = error_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    fill_enable = 1'b0;
    fill_ack    = 1'b0;
    cmd_done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_fire) begin
          state_next = CLIP;
        end
      end
      CLIP: begin
        state_next = clip_empty ? COMPLETE : RUN;
      end
      RUN: begin
        fill_enable = 1'b1;
        if (fill_done) begin
          state_next = ACK;
        end else if (wd_expire) begin
          state_next = COMPLETE;
        end
      end
      ACK: begin
        fill_enable = 1'b1;
        fill_ack    = 1'b1;
        state_next  = COMPLETE;
      end
      COMPLETE: begin
        cmd_done   = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // RAM write port: engine while it is enabled, granted pixel writer in IDLE.
  always_comb begin
    ram_row          = '0;
    ram_column       = '0;
    ram_pixel        = '0;
    ram_data         = '0;
    ram_write_enable = 1'b0;
    if ((state == RUN) || (state == ACK)) begin
      ram_row          = fill_row;
      ram_column       = fill_column;
      ram_pixel        = fill_pixel;
      ram_data         = fill_data;
      ram_write_enable = fill_we;
    end else if (px_gnt) begin
      ram_row          = px_row;
      ram_column       = px_column;
      ram_pixel        = px_pixel;
      ram_data         = px_data;
      ram_write_enable = 1'b1;
    end
  end

endmodule : control_subcmd_scheduler
